imem_loader: RTL and testbench

//  Boot-time program loader and port sequencer for the single-port instruction memory.

---
 rtl/imem_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader and port sequencer for a single-port instruction
// memory. After reset it accepts a stream of 32-bit instruction words and
// writes them to consecutive word addresses. If the program is shorter than the
// memory, the remaining tail is padded with FILL_WORD. It then releases the
// core (o_cpu_run) and hands the memory address port over to the fetch PC.
//
// Ports
//   i_clk           rising-edge clock
//   i_reset         asynchronous assert, active-high
//   i_load_valid    load stream word valid
//   o_load_ready    loader accepts a word this cycle (LOAD state only)
//   i_load_data     instruction word
//   i_load_last     final word of the program (sampled only on handshake)
//   i_pc            core fetch byte address
//   o_imem_we       memory write enable (memory writes on posedge i_clk)
//   o_imem_addr     memory word address, shared by loader writes and fetch
//   o_imem_wdata    memory write data
//   o_cpu_run       core may fetch/execute; 0 holds the core stalled
//   o_fetch_fault   pc is misaligned or beyond DEPTH words (only while running)
//   o_words_loaded  number of program words accepted from the stream
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int          DEPTH     = 8,
    parameter int          AW        = $clog2(DEPTH),
    parameter logic [31:0] FILL_WORD = 32'h0000_0013
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load_valid,
    output logic          o_load_ready,
    input  logic [31:0]   i_load_data,
    input  logic          i_load_last,
    input  logic [31:0]   i_pc,
    output logic          o_imem_we,
    output logic [AW-1:0] o_imem_addr,
    output logic [31:0]   o_imem_wdata,
    output logic          o_cpu_run,
    output logic          o_fetch_fault,
    output logic [AW:0]   o_words_loaded
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_words_loaded;
    logic          r_cpu_run;

    logic          w_handshake;
    logic          w_ptr_at_end;
    logic          w_ptr_adv;

    assign w_handshake  = (r_state == ST_LOAD) & i_load_valid;
    assign w_ptr_at_end = (r_wr_ptr == AW'(DEPTH - 1));
    // Every LOAD handshake and every FILL cycle consumes exactly one word slot.
    assign w_ptr_adv    = w_handshake | (r_state == ST_FILL);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_handshake) begin
                    // A word landing in the last slot fills the memory, so
                    // load_last no longer matters and no padding is needed.
                    if (w_ptr_at_end) begin
                        w_state_next = ST_RUN;
                    end else if (i_load_last) begin
                        w_state_next = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (w_ptr_at_end) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_LOAD;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers: write pointer, accepted-word counter, run flag
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr       <= '0;
            r_words_loaded <= '0;
            r_cpu_run      <= 1'b0;
        end else begin
            // DEPTH is a power of two, so the pointer wraps to 0 on its own
            // after the last slot is written.
            if (w_ptr_adv) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_handshake) begin
                r_words_loaded <= r_words_loaded + (AW+1)'(1);
            end
            // Rises in the cycle after the final memory write.
            r_cpu_run <= (w_state_next == ST_RUN);
        end
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        o_load_ready = 1'b0;
        o_imem_we    = 1'b0;
        o_imem_addr  = r_wr_ptr;
        o_imem_wdata = i_load_data;
        case (r_state)
            ST_LOAD: begin
                o_load_ready = 1'b1;
                o_imem_we    = i_load_valid;
            end
            ST_FILL: begin
                o_imem_we    = 1'b1;
                o_imem_wdata = FILL_WORD;
            end
            ST_RUN: begin
                // Fetch owns the address port; word address from the byte PC.
                o_imem_addr  = i_pc[AW+1:2];
            end
            default: begin
                o_load_ready = 1'b0;
            end
        endcase
    end

    // The address still follows the PC on a fault; the core decides what to do.
    assign o_fetch_fault  = r_cpu_run &
                            ((i_pc[1:0] != 2'b00) | (i_pc[31:AW+2] != '0));
    assign o_cpu_run      = r_cpu_run;
    assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. Offered stream words are recorded; a
// reference model turns them into the list of memory writes the loader must
// perform (program words at 0.., then FILL padding) and into an expected memory
// image. A negedge monitor records the writes the DUT actually performs into a
// behavioural memory, and each scenario task compares the two.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int          DEPTH = 8;
    localparam int          AW    = 3;
    localparam logic [31:0] FILL  = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [31:0]   load_data;
    logic          load_last;
    logic [31:0]   pc;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_run;
    logic          fetch_fault;
    logic [AW:0]   words_loaded;

    imem_loader #(.DEPTH(DEPTH), .FILL_WORD(FILL)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_load_valid   (load_valid),
        .o_load_ready   (load_ready),
        .i_load_data    (load_data),
        .i_load_last    (load_last),
        .i_pc           (pc),
        .o_imem_we      (imem_we),
        .o_imem_addr    (imem_addr),
        .o_imem_wdata   (imem_wdata),
        .o_cpu_run      (cpu_run),
        .o_fetch_fault  (fetch_fault),
        .o_words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Monitor state
    int          cyc = 0;
    int          run_cyc = -1;
    int          halted_faults = 0;
    int          log_addr[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];
    logic [31:0] mem_img [DEPTH];

    // Stimulus record and reference model
    logic [31:0] off_data[$];
    bit          off_last[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_loaded;
    logic [31:0] exp_img [DEPTH];

    // Behavioural memory + write log, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_we) begin
                log_addr.push_back(int'(imem_addr));
                log_data.push_back(imem_wdata);
                log_cyc.push_back(cyc);
                mem_img[imem_addr] = imem_wdata;
            end
            if (cpu_run && run_cyc < 0) run_cyc = cyc;
            if (!cpu_run && fetch_fault) halted_faults++;
        end
        cyc++;
    end

    // Expected writes: program words land at 0,1,2,...; the stream stops being
    // accepted after load_last (then the tail is padded) or when the memory is full.
    task automatic build_model();
        int  nxt = 0;
        bit  stop = 0;
        bit  pad = 0;
        exp_addr.delete();
        exp_data.delete();
        exp_loaded = 0;
        foreach (off_data[i]) begin
            if (!stop) begin
                exp_addr.push_back(nxt);
                exp_data.push_back(off_data[i]);
                exp_loaded++;
                nxt++;
                if (nxt == DEPTH) stop = 1;
                else if (off_last[i]) begin stop = 1; pad = 1; end
            end
        end
        if (pad) for (int a = nxt; a < DEPTH; a++) begin
            exp_addr.push_back(a);
            exp_data.push_back(FILL);
        end
        foreach (exp_addr[i]) exp_img[exp_addr[i]] = exp_data[i];
    endtask

    task automatic clear_tb_state();
        log_addr.delete(); log_data.delete(); log_cyc.delete();
        off_data.delete(); off_last.delete();
        run_cyc = -1;
        halted_faults = 0;
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        load_valid = 0; load_last = 0; reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        clear_tb_state();
    endtask

    task automatic offer(input logic [31:0] d, input bit last);
        @(posedge clk); #1;
        load_valid = 1; load_data = d; load_last = last; pc = $urandom;
        off_data.push_back(d);
        off_last.push_back(last);
    endtask

    // mode 0: load_last=0, 1: load_last=1, 2: random load_last
    task automatic idle(input int n, input int mode);
        repeat (n) begin
            @(posedge clk); #1;
            load_valid = 0;
            load_data  = $urandom;
            load_last  = (mode == 2) ? 1'($urandom) : (mode == 1);
            pc         = $urandom;
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1; load_valid = 0; load_last = 0; load_data = 0; pc = 32'h20;
        #1;
        n_vec++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", load_ready); end
        n_vec++; if (cpu_run !== 1'b0) begin n_err++; $display("FAIL reset_run: got %b expected 0", cpu_run); end
        n_vec++; if (words_loaded !== '0) begin n_err++; $display("FAIL reset_words: got %0d expected 0", words_loaded); end
        n_vec++; if (imem_we !== 1'b0 || fetch_fault !== 1'b0) begin n_err++; $display("FAIL reset_we_fault: got we=%b fault=%b expected 0 0", imem_we, fetch_fault); end
        repeat (2) @(posedge clk);
        #1 reset = 0;
        clear_tb_state();

        // Reset after 3 accepted words: immediate return to LOAD.
        for (int k = 0; k < 3; k++) offer($urandom, 0);
        idle(1, 0);
        build_model();
        n_vec++; if (words_loaded !== 4'd3) begin n_err++; $display("FAIL midload_words: got %0d expected 3", words_loaded); end
        @(posedge clk); #3 reset = 1;
        #1;
        n_vec++; if (load_ready !== 1'b1 || cpu_run !== 1'b0 || words_loaded !== '0) begin
            n_err++; $display("FAIL midload_async: got ready=%b run=%b words=%0d expected 1 0 0", load_ready, cpu_run, words_loaded);
        end
        @(posedge clk); #1 reset = 0;
        clear_tb_state();
        offer(32'hCAFE_0001, 0);
        offer(32'hCAFE_0002, 1);
        idle(DEPTH + 2, 0);
        build_model();
        n_vec++; if (log_addr.size() == 0 || log_addr[0] != 0 || log_data[0] !== 32'hCAFE_0001) begin
            n_err++; $display("FAIL restart_first_write: got %0d writes expected addr 0 data cafe0001", log_addr.size());
        end
        n_vec++; if (words_loaded !== 4'd2) begin n_err++; $display("FAIL restart_words: got %0d expected 2", words_loaded); end
        foreach (exp_img[i]) begin
            n_vec++; if (mem_img[i] !== exp_img[i]) begin n_err++; $display("FAIL restart_img[%0d]: got %h expected %h", i, mem_img[i], exp_img[i]); end
        end

        // Reset while running drops cpu_run at once.
        n_vec++; if (cpu_run !== 1'b1) begin n_err++; $display("FAIL run_before_reset: got %b expected 1", cpu_run); end
        @(posedge clk); #3 reset = 1;
        #1;
        n_vec++; if (cpu_run !== 1'b0 || load_ready !== 1'b1) begin n_err++; $display("FAIL runreset_async: got run=%b ready=%b expected 0 1", cpu_run, load_ready); end
        @(posedge clk); #1 reset = 0;
        clear_tb_state();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_basic();
        logic [31:0] prog [5] = '{32'h00200093, 32'h00900113, 32'h00000193, 32'h0011A023, 32'h0021A223};
        for (int it = 0; it < 6; it++) begin
            int n;
            reset_dut();
            n = (it == 0) ? 5 : $urandom_range(1, DEPTH);
            for (int k = 0; k < n; k++)
                offer((it == 0) ? prog[k] : $urandom, (k == n - 1) ? 1'b1 : 1'b0);
            idle(DEPTH + 3, 0);
            #1;
            build_model();
            n_vec++; if (log_addr.size() != exp_addr.size()) begin n_err++; $display("FAIL basic%0d count: got %0d expected %0d", it, log_addr.size(), exp_addr.size()); end
            for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
                n_vec++; if (log_addr[i] != exp_addr[i] || log_data[i] !== exp_data[i]) begin
                    n_err++; $display("FAIL basic%0d write[%0d]: got %0d/%h expected %0d/%h", it, i, log_addr[i], log_data[i], exp_addr[i], exp_data[i]);
                end
                if (i >= exp_loaded) begin
                    n_vec++; if (log_cyc[i] != log_cyc[i-1] + 1) begin n_err++; $display("FAIL basic%0d fill_gap[%0d]: got cycle %0d expected %0d", it, i, log_cyc[i], log_cyc[i-1] + 1); end
                end
            end
            n_vec++; if (log_cyc.size() == 0 || run_cyc != log_cyc[$] + 1) begin n_err++; $display("FAIL basic%0d run_cycle: got %0d expected one after last write", it, run_cyc); end
            n_vec++; if (words_loaded !== (AW+1)'(exp_loaded)) begin n_err++; $display("FAIL basic%0d words: got %0d expected %0d", it, words_loaded, exp_loaded); end
            n_vec++; if (load_ready !== 1'b0 || imem_we !== 1'b0 || halted_faults != 0) begin n_err++; $display("FAIL basic%0d run_outputs: got ready=%b we=%b hfaults=%0d expected 0 0 0", it, load_ready, imem_we, halted_faults); end
            foreach (exp_img[i]) begin
                n_vec++; if (mem_img[i] !== exp_img[i]) begin n_err++; $display("FAIL basic%0d img[%0d]: got %h expected %h", it, i, mem_img[i], exp_img[i]); end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_backpressure();
        for (int it = 0; it < 5; it++) begin
            int n;
            reset_dut();
            if (it == 0) begin
                // valid pattern 1,0,0,1,0,1 with last on word 3
                offer($urandom, 0); idle(2, 0);
                offer($urandom, 0); idle(1, 0);
                offer($urandom, 1);
            end else begin
                n = $urandom_range(1, DEPTH - 1);
                for (int k = 0; k < n; k++) begin
                    idle($urandom_range(0, 3), 2);
                    offer($urandom, (k == n - 1) ? 1'b1 : 1'b0);
                end
            end
            idle(DEPTH + 3, 0);
            #1;
            build_model();
            n_vec++; if (log_addr.size() != exp_addr.size()) begin n_err++; $display("FAIL bp%0d count: got %0d expected %0d", it, log_addr.size(), exp_addr.size()); end
            for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
                n_vec++; if (log_addr[i] != exp_addr[i] || log_data[i] !== exp_data[i]) begin
                    n_err++; $display("FAIL bp%0d write[%0d]: got %0d/%h expected %0d/%h", it, i, log_addr[i], log_data[i], exp_addr[i], exp_data[i]);
                end
                if (i >= exp_loaded) begin
                    n_vec++; if (log_cyc[i] != log_cyc[i-1] + 1) begin n_err++; $display("FAIL bp%0d fill_gap[%0d]: got cycle %0d expected %0d", it, i, log_cyc[i], log_cyc[i-1] + 1); end
                end
            end
            n_vec++; if (log_cyc.size() == 0 || run_cyc != log_cyc[$] + 1) begin n_err++; $display("FAIL bp%0d run_cycle: got %0d expected one after last write", it, run_cyc); end
            n_vec++; if (words_loaded !== (AW+1)'(exp_loaded)) begin n_err++; $display("FAIL bp%0d words: got %0d expected %0d", it, words_loaded, exp_loaded); end
            foreach (exp_img[i]) begin
                n_vec++; if (mem_img[i] !== exp_img[i]) begin n_err++; $display("FAIL bp%0d img[%0d]: got %h expected %h", it, i, mem_img[i], exp_img[i]); end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_overflow();
        for (int it = 0; it < 3; it++) begin
            reset_dut();
            // DEPTH words without last (last on the final slot when it>0 must be
            // ignored), then extra words that must never be written.
            for (int k = 0; k < DEPTH + 1 + it; k++)
                offer($urandom, (it > 0 && k == DEPTH - 1) ? 1'b1 : 1'b0);
            #1;
            n_vec++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL ovf%0d ready_after_full: got %b expected 0", it, load_ready); end
            n_vec++; if (imem_we !== 1'b0) begin n_err++; $display("FAIL ovf%0d extra_word_we: got %b expected 0", it, imem_we); end
            idle(4, 0);
            #1;
            build_model();
            n_vec++; if (log_addr.size() != exp_addr.size()) begin n_err++; $display("FAIL ovf%0d count: got %0d expected %0d", it, log_addr.size(), exp_addr.size()); end
            for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
                n_vec++; if (log_addr[i] != exp_addr[i] || log_data[i] !== exp_data[i]) begin
                    n_err++; $display("FAIL ovf%0d write[%0d]: got %0d/%h expected %0d/%h", it, i, log_addr[i], log_data[i], exp_addr[i], exp_data[i]);
                end
            end
            n_vec++; if (log_cyc.size() == 0 || run_cyc != log_cyc[$] + 1) begin n_err++; $display("FAIL ovf%0d run_cycle: got %0d expected one after last write", it, run_cyc); end
            n_vec++; if (words_loaded !== (AW+1)'(exp_loaded)) begin n_err++; $display("FAIL ovf%0d words: got %0d expected %0d", it, words_loaded, exp_loaded); end
            foreach (exp_img[i]) begin
                n_vec++; if (mem_img[i] !== exp_img[i]) begin n_err++; $display("FAIL ovf%0d img[%0d]: got %h expected %h", it, i, mem_img[i], exp_img[i]); end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_last_idle();
        reset_dut();
        idle(5, 1);
        #1;
        n_vec++; if (log_addr.size() != 0 || words_loaded !== '0 || load_ready !== 1'b1 || cpu_run !== 1'b0) begin
            n_err++; $display("FAIL lastidle_nochange: got writes=%0d words=%0d ready=%b run=%b expected 0 0 1 0", log_addr.size(), words_loaded, load_ready, cpu_run);
        end
        offer($urandom, 1);
        idle(DEPTH + 3, 0);
        #1;
        build_model();
        n_vec++; if (log_addr.size() != exp_addr.size()) begin n_err++; $display("FAIL single count: got %0d expected %0d", log_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
            n_vec++; if (log_addr[i] != exp_addr[i] || log_data[i] !== exp_data[i]) begin
                n_err++; $display("FAIL single write[%0d]: got %0d/%h expected %0d/%h", i, log_addr[i], log_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_vec++; if (log_cyc.size() == 0 || run_cyc != log_cyc[$] + 1) begin n_err++; $display("FAIL single run_cycle: got %0d expected one after last write", run_cyc); end
        n_vec++; if (words_loaded !== 4'd1) begin n_err++; $display("FAIL single words: got %0d expected 1", words_loaded); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_run_fetch();
        logic [31:0] fixed_pc [4] = '{32'h10, 32'h1C, 32'h20, 32'h06};
        // Loader is already in RUN after test_last_idle.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] p;
            int          e_addr;
            bit          e_fault;
            if (i < 4)       p = fixed_pc[i];
            else if (i & 1)  p = 32'($urandom_range(0, 4 * DEPTH + 7));
            else             p = $urandom;
            e_addr  = int'(p / 4) % DEPTH;
            e_fault = (p % 4 != 0) || (p >= 32'(4 * DEPTH));
            @(posedge clk); #1;
            pc = p; load_valid = 1'($urandom); load_data = $urandom; load_last = 1'($urandom);
            #1;
            n_vec++; if (int'(imem_addr) != e_addr || fetch_fault !== e_fault) begin
                n_err++; $display("FAIL fetch pc=%h: got addr %0d fault %b expected addr %0d fault %b", p, imem_addr, fetch_fault, e_addr, e_fault);
            end
            n_vec++; if (imem_we !== 1'b0 || load_ready !== 1'b0 || cpu_run !== 1'b1) begin
                n_err++; $display("FAIL fetch_ctrl pc=%h: got we=%b ready=%b run=%b expected 0 0 1", p, imem_we, load_ready, cpu_run);
            end
        end
        idle(1, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_img[i] = 32'hDEAD_0000 + 32'(i);
            exp_img[i] = 32'hDEAD_0000 + 32'(i);
        end
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_last_idle();
        test_run_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
